// File: rtl/debounce_fsm_if.sv
// Switch/debounce signal bundle for debounce_fsm.
// master drives the raw switch level and the sample strobe; slave is the
// debouncer, which returns the debounced level, edge pulses and busy flag.
interface debounce_fsm_if;
  logic sw;
  logic tick;
  logic db_level;
  logic db_rise;
  logic db_fall;
  logic busy;

  modport master (
    output sw,
    output tick,
    input  db_level,
    input  db_rise,
    input  db_fall,
    input  busy
  );

  modport slave (
    input  sw,
    input  tick,
    output db_level,
    output db_rise,
    output db_fall,
    output busy
  );
endinterface

// File: rtl/debounce_fsm.sv
// Tick-qualified switch debouncer.
// A level change on the switch is accepted only after it has been held for
// N_TICKS consecutive sample strobes. Short excursions are rejected without
// any output pulse. All outputs are registered.
// Optional feature: define DEBOUNCE_SYNC_EN to pass the raw switch through a
// two-flop synchronizer (sw_s lags sw by two clocks); otherwise sw is used
// directly and must already be synchronous to clk.
module debounce_fsm #(
  parameter int N_TICKS = 3  // legal range 1..15
) (
  input logic         clk,
  input logic         reset,
  debounce_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [3:0] N_LIM = 4'(N_TICKS);

  logic sw_s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for the asynchronous raw switch level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.sw};
    end
  end

  assign sw_s = sync_q[1];
`else
  assign sw_s = bus.sw;
`endif

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [3:0] cnt_inc;
  logic       level_q, rise_q, fall_q, busy_q;

  assign cnt_inc = cnt + 4'd1;

  // Next-state and tick-count logic. An abort level always beats a tick,
  // and the cycle that enters a WAIT state never counts its tick because the
  // counting branch is only reachable from inside a WAIT state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          cnt_next   = '0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
          cnt_next   = '0;
        end else if (bus.tick) begin
          if (cnt_inc == N_LIM) begin
            state_next = ONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
          cnt_next   = '0;
        end else if (bus.tick) begin
          if (cnt_inc == N_LIM) begin
            state_next = ZERO;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      default: begin
        state_next = ZERO;
        cnt_next   = '0;
      end
    endcase
  end

  // State register plus registered outputs decoded from the upcoming state,
  // so db_level/busy track the state flop exactly and the edge pulses last
  // one cycle after the accepting edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: reset is synchronous and takes priority over every input;
      // in-flight qualification is dropped without emitting a pulse.
      state   <= ZERO;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      level_q <= (state_next == ONE) || (state_next == WAIT0);
      rise_q  <= (state == WAIT1) && (state_next == ONE);
      fall_q  <= (state == WAIT0) && (state_next == ZERO);
      busy_q  <= (state_next == WAIT1) || (state_next == WAIT0);
    end
  end

  assign bus.db_level = level_q;
  assign bus.db_rise  = rise_q;
  assign bus.db_fall  = fall_q;
  assign bus.busy     = busy_q;

endmodule
